branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Sits directly downstream of the EX-stage subtractor. It consumes that subtractor's zero and neg flags together with the decoded branch op, and resolves conditional branches.
- Static predict-not-taken: every taken branch is a mispredict. For each one it issues a registered PC redirect and a multi-cycle flush of the IF/ID and ID/EX pipeline registers.
- Keeps saturating branch and taken statistics counters for debug.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is held high per taken branch; legal range 1..15.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX stage holds a real instruction this cycle.
- ex_branch_op  input  3  branch kind, encoded per the shared package.
- ex_pc_plus4  input  32  PC+4 of the EX instruction.
- ex_imm  input  32  sign-extended 16-bit branch offset, in words.
- sub_zero  input  1  subtractor result == 0.
- sub_neg  input  1  subtractor result < 0 (signed).
- stall  input  1  pipeline stall; freezes evaluation and the flush countdown.
- redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  output  32  branch target; holds its last value between redirects.
- flush  output  1  squash IF/ID and ID/EX contents.
- busy  output  1  FSM is not in IDLE.
- branch_cnt  output  CNT_W  number of branches evaluated.
- taken_cnt  output  CNT_W  number of branches taken.

Behaviour:
- Reset values: all outputs 0 (redirect_pc = 32'h0, both counters 0); FSM in IDLE; flush counter 0.
- Evaluate condition: ex_valid && !stall && state==IDLE && op is not NONE or reserved.
- Taken rules (the subtractor computes rs-rt, or rs-0 for single-operand forms):
  - BEQ: zero
  - BNE: !zero
  - BLEZ: zero|neg
  - BGTZ: !zero&&!neg
  - BLTZ: neg
  - BGEZ: !neg
- Target: ex_pc_plus4 + (ex_imm << 2), 32-bit modulo (wraps, no overflow flag).
- Latency: outputs are registered and appear one cycle after the evaluating edge.
- FSM:
  - IDLE -> REDIRECT on an evaluated taken branch; otherwise stays in IDLE.
  - REDIRECT (always exactly 1 cycle, ignores stall): redirect_valid=1, flush=1, busy=1. Goes to FLUSH if FLUSH_CYCLES>1, else to IDLE.
  - FLUSH: flush=1, busy=1, counts down FLUSH_CYCLES-1 cycles. Countdown is frozen while stall=1. Returns to IDLE when it expires.
- While state != IDLE, all ex_* inputs are wrong-path and are ignored: no redirect, no counter updates.
- Counters:
  - branch_cnt += 1 per evaluation.
  - taken_cnt += 1 per taken evaluation.
  - Both saturate at all-ones and never wrap.
- Reserved op 3'b111 behaves as NONE: never counted, never taken.
- Reset mid-REDIRECT/FLUSH: the next cycle is IDLE with flush=0, redirect_valid=0 and counters cleared.
- A stall on the evaluating cycle means no evaluation: the instruction is re-presented later and evaluated once stall drops. This guarantees no double count.

Decomposition:
- Shared package branch_defs:
  - BR_NONE=3'd0, BR_BEQ=1, BR_BNE=2, BR_BLEZ=3, BR_BGTZ=4, BR_BLTZ=5, BR_BGEZ=6, BR_RSVD=7.
  - FSM state encodings ST_IDLE, ST_REDIRECT, ST_FLUSH.
- One natural sub-module: sat_counter (parameter W, inputs clk/reset/inc, saturating output). It is instantiated twice, once for each statistics counter.

Test Plan:
- BEQ taken, no stall:
  - Stimulus: BEQ, sub_zero=1, ex_pc_plus4=0x00400010, ex_imm=0xFFFFFFFC.
  - Next cycle: redirect_valid=1, redirect_pc=0x00400000, flush=1.
  - Flush stays high for 2 cycles total; branch_cnt=1, taken_cnt=1.
- BNE not taken:
  - Stimulus: BNE, sub_zero=1.
  - Response: no redirect, flush stays 0, branch_cnt=1, taken_cnt=0.
- Signed compares:
  - BLTZ, neg=1, imm=0x00000004, pc_plus4=0x1000 -> redirect to 0x1010.
  - BGEZ, neg=1 -> not taken.
  - BLEZ, zero=1 -> taken.
  - BGTZ, zero=0, neg=0 -> taken.
- Stall during FLUSH (FLUSH_CYCLES=3):
  - Stimulus: taken BEQ, then stall=1 for 2 cycles on the first FLUSH cycle.
  - Response: flush stays high 5 cycles total.
  - A second BEQ presented during FLUSH is ignored: taken_cnt stays 1.
- Reset mid-flush:
  - Stimulus: assert reset on the REDIRECT cycle.
  - Next cycle: flush=0, busy=0, counters=0, redirect_pc=0.
- Saturation (CNT_W=4):
  - Stimulus: 17 taken branches, each separated by a completed flush.
  - Response: branch_cnt=taken_cnt=4'hF, no wrap.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared branch-op and resolver-state encodings plus the condition evaluator.
package branch_defs;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned FCNT_W = 4;

  typedef enum logic [OP_W-1:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } br_state_e;

  // True for real conditional branches; NONE and the reserved code never evaluate.
  function automatic logic br_is_cond(input logic [OP_W-1:0] op);
    return (op != BR_NONE) && (op != BR_RSVD);
  endfunction

  // Flags come from rs-rt (or rs-0 for the single-operand forms).
  function automatic logic br_taken(input logic [OP_W-1:0] op, input logic zero,
                                    input logic neg);
    logic t;
    t = 1'b0;
    case (br_op_e'(op))
      BR_BEQ:  t = zero;
      BR_BNE:  t = !zero;
      BR_BLEZ: t = zero | neg;
      BR_BGTZ: t = !zero && !neg;
      BR_BLTZ: t = neg;
      BR_BGEZ: t = !neg;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: predict-not-taken, so every taken branch redirects
// fetch and squashes the younger pipeline stages for FLUSH_CYCLES cycles.
module branch_resolver
  import branch_defs::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_branch_op,
  input  logic [XLEN-1:0]   ex_pc_plus4,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic              sub_zero,
  input  logic              sub_neg,
  input  logic              stall,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  br_state_e         state;
  logic [FCNT_W-1:0] fcnt;
  logic              eval_c;
  logic              taken_c;
  logic [XLEN-1:0]   target_c;

  // Only an un-stalled, in-IDLE instruction is evaluated; everything else is wrong-path or retried.
  assign eval_c   = ex_valid && !stall && (state == ST_IDLE) && br_is_cond(ex_branch_op);
  assign taken_c  = eval_c && br_taken(ex_branch_op, sub_zero, sub_neg);
  assign target_c = ex_pc_plus4 + (ex_imm << 2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      fcnt           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (taken_c) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target_c;
            flush          <= 1'b1;
            busy           <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          // The redirect cycle itself counts as the first flush cycle.
          if (FLUSH_CYCLES > 1) begin
            state <= ST_FLUSH;
            fcnt  <= FCNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state <= ST_IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (!stall) begin
            if (fcnt < FCNT_W'(2)) begin
              state <= ST_IDLE;
              fcnt  <= '0;
              flush <= 1'b0;
              busy  <= 1'b0;
            end else begin
              fcnt <= fcnt - FCNT_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          fcnt  <= '0;
          flush <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (eval_c),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (taken_c),
    .count (taken_cnt)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: three configurations share one clock,
// expected responses are queued at stimulus time and checked after each edge.
module tb_branch_resolver;
  import branch_defs::*;

  typedef struct packed {
    logic        reset;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        zero;
    logic        neg;
    logic        stall;
  } in_t;

  typedef struct {
    string       tag;
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        bz;
    logic [31:0] bc;
    logic [31:0] tc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t i0, i1, i2;
  logic        rv0, rv1, rv2, fl0, fl1, fl2, bz0, bz1, bz2;
  logic [31:0] rpc0, rpc1, rpc2, bc0, tc0, bc1, tc1;
  logic [3:0]  bc2, tc2;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  branch_resolver #(.FLUSH_CYCLES(2), .CNT_W(32)) u_def (
    .clk(clk), .reset(i0.reset), .ex_valid(i0.valid), .ex_branch_op(i0.op),
    .ex_pc_plus4(i0.pc4), .ex_imm(i0.imm), .sub_zero(i0.zero), .sub_neg(i0.neg),
    .stall(i0.stall), .redirect_valid(rv0), .redirect_pc(rpc0), .flush(fl0),
    .busy(bz0), .branch_cnt(bc0), .taken_cnt(tc0));

  branch_resolver #(.FLUSH_CYCLES(3), .CNT_W(32)) u_f3 (
    .clk(clk), .reset(i1.reset), .ex_valid(i1.valid), .ex_branch_op(i1.op),
    .ex_pc_plus4(i1.pc4), .ex_imm(i1.imm), .sub_zero(i1.zero), .sub_neg(i1.neg),
    .stall(i1.stall), .redirect_valid(rv1), .redirect_pc(rpc1), .flush(fl1),
    .busy(bz1), .branch_cnt(bc1), .taken_cnt(tc1));

  branch_resolver #(.FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(i2.reset), .ex_valid(i2.valid), .ex_branch_op(i2.op),
    .ex_pc_plus4(i2.pc4), .ex_imm(i2.imm), .sub_zero(i2.zero), .sub_neg(i2.neg),
    .stall(i2.stall), .redirect_valid(rv2), .redirect_pc(rpc2), .flush(fl2),
    .busy(bz2), .branch_cnt(bc2), .taken_cnt(tc2));

  function automatic in_t br(input logic [2:0] op, input logic [31:0] pc4,
                             input logic [31:0] imm, input logic z, input logic n);
    in_t v;
    v = '0;
    v.valid = 1'b1;
    v.op    = op;
    v.pc4   = pc4;
    v.imm   = imm;
    v.zero  = z;
    v.neg   = n;
    return v;
  endfunction

  task automatic set_in(input int d, input in_t v);
    case (d)
      0: i0 = v;
      1: i1 = v;
      default: i2 = v;
    endcase
  endtask

  task automatic want(input string tag, input logic rv, input logic [31:0] pc,
                      input logic fl, input logic bz, input logic [31:0] bc,
                      input logic [31:0] tc);
    exp_t e;
    e.tag = tag; e.rv = rv; e.pc = pc; e.fl = fl; e.bz = bz; e.bc = bc; e.tc = tc;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp_v);
    end
  endtask

  task automatic check(input int d);
    exp_t e;
    logic rv, fl, bz;
    logic [31:0] pc, bc, tc;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = q.pop_front();
    case (d)
      0: begin rv = rv0; pc = rpc0; fl = fl0; bz = bz0; bc = bc0; tc = tc0; end
      1: begin rv = rv1; pc = rpc1; fl = fl1; bz = bz1; bc = bc1; tc = tc1; end
      default: begin
        rv = rv2; pc = rpc2; fl = fl2; bz = bz2; bc = 32'(bc2); tc = 32'(tc2);
      end
    endcase
    cmp(e.tag, "redirect_valid", 32'(rv), 32'(e.rv));
    cmp(e.tag, "redirect_pc", pc, e.pc);
    cmp(e.tag, "flush", 32'(fl), 32'(e.fl));
    cmp(e.tag, "busy", 32'(bz), 32'(e.bz));
    cmp(e.tag, "branch_cnt", bc, e.bc);
    cmp(e.tag, "taken_cnt", tc, e.tc);
  endtask

  // One clock on DUT d, checking the next queued expectation.
  task automatic step(input int d, input string tag, input logic rv, input logic [31:0] pc,
                      input logic fl, input logic bz, input logic [31:0] bc,
                      input logic [31:0] tc);
    want(tag, rv, pc, fl, bz, bc, tc);
    tick();
    check(d);
  endtask

  initial begin
    in_t v;
    in_t idle;
    idle = '0;
    v = '0;
    v.reset = 1'b1;
    i0 = v; i1 = v; i2 = v;
    tick();
    for (int d = 0; d < 3; d++) want("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check(0); check(1); check(2);
    i0 = idle; i1 = idle; i2 = idle;

    // Default config: BEQ taken, wrong-path BEQ held through REDIRECT/FLUSH.
    set_in(0, br(BR_BEQ, 32'h0040_0010, 32'hFFFF_FFFC, 1'b1, 1'b0));
    step(0, "beq_redirect", 1'b1, 32'h0040_0000, 1'b1, 1'b1, 32'd1, 32'd1);
    step(0, "beq_flush",    1'b0, 32'h0040_0000, 1'b1, 1'b1, 32'd1, 32'd1);
    step(0, "beq_done",     1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'd1, 32'd1);
    set_in(0, br(BR_BNE, 32'h0000_5000, 32'h8, 1'b1, 1'b0));
    step(0, "bne_not_taken", 1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'd2, 32'd1);
    set_in(0, idle);
    step(0, "bne_quiet",     1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'd2, 32'd1);

    set_in(0, br(BR_BLTZ, 32'h0000_1000, 32'h4, 1'b0, 1'b1));
    step(0, "bltz_taken", 1'b1, 32'h0000_1010, 1'b1, 1'b1, 32'd3, 32'd2);
    set_in(0, idle);
    step(0, "bltz_flush", 1'b0, 32'h0000_1010, 1'b1, 1'b1, 32'd3, 32'd2);
    step(0, "bltz_done",  1'b0, 32'h0000_1010, 1'b0, 1'b0, 32'd3, 32'd2);

    set_in(0, br(BR_BGEZ, 32'h0000_7000, 32'h0, 1'b0, 1'b1));
    step(0, "bgez_not_taken", 1'b0, 32'h0000_1010, 1'b0, 1'b0, 32'd4, 32'd2);

    set_in(0, br(BR_BLEZ, 32'h0000_2000, 32'h0, 1'b1, 1'b0));
    step(0, "blez_taken", 1'b1, 32'h0000_2000, 1'b1, 1'b1, 32'd5, 32'd3);
    set_in(0, idle);
    step(0, "blez_flush", 1'b0, 32'h0000_2000, 1'b1, 1'b1, 32'd5, 32'd3);
    step(0, "blez_done",  1'b0, 32'h0000_2000, 1'b0, 1'b0, 32'd5, 32'd3);

    set_in(0, br(BR_BGTZ, 32'h0000_3000, 32'hFFFF_FFFF, 1'b0, 1'b0));
    step(0, "bgtz_taken", 1'b1, 32'h0000_2FFC, 1'b1, 1'b1, 32'd6, 32'd4);
    set_in(0, idle);
    step(0, "bgtz_flush", 1'b0, 32'h0000_2FFC, 1'b1, 1'b1, 32'd6, 32'd4);
    step(0, "bgtz_done",  1'b0, 32'h0000_2FFC, 1'b0, 1'b0, 32'd6, 32'd4);

    // Non-evaluating inputs: reserved op, NONE, and ex_valid low.
    set_in(0, br(BR_RSVD, 32'h0000_9000, 32'h4, 1'b1, 1'b1));
    step(0, "rsvd_ignored", 1'b0, 32'h0000_2FFC, 1'b0, 1'b0, 32'd6, 32'd4);
    set_in(0, br(BR_NONE, 32'h0000_9000, 32'h4, 1'b1, 1'b0));
    step(0, "none_ignored", 1'b0, 32'h0000_2FFC, 1'b0, 1'b0, 32'd6, 32'd4);
    v = br(BR_BEQ, 32'h0000_9000, 32'h4, 1'b1, 1'b0);
    v.valid = 1'b0;
    set_in(0, v);
    step(0, "invalid_ignored", 1'b0, 32'h0000_2FFC, 1'b0, 1'b0, 32'd6, 32'd4);

    // Stalled evaluation is retried once; target wraps modulo 2^32.
    v = br(BR_BEQ, 32'hFFFF_FFFC, 32'h2, 1'b1, 1'b0);
    v.stall = 1'b1;
    set_in(0, v);
    step(0, "stall_no_eval", 1'b0, 32'h0000_2FFC, 1'b0, 1'b0, 32'd6, 32'd4);
    v.stall = 1'b0;
    set_in(0, v);
    step(0, "wrap_taken", 1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'd7, 32'd5);
    set_in(0, idle);
    step(0, "wrap_flush", 1'b0, 32'h0000_0004, 1'b1, 1'b1, 32'd7, 32'd5);
    step(0, "wrap_done",  1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'd7, 32'd5);
    set_in(0, br(BR_BEQ, 32'h0000_8000, 32'h0, 1'b0, 1'b0));
    step(0, "beq_not_taken", 1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'd8, 32'd5);
    set_in(0, br(BR_BLTZ, 32'h0000_8000, 32'h0, 1'b0, 1'b0));
    step(0, "bltz_not_taken", 1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'd9, 32'd5);
    set_in(0, idle);

    // FLUSH_CYCLES=3: stall freezes the countdown, wrong-path BEQ ignored.
    v = br(BR_BEQ, 32'h0000_0100, 32'h1, 1'b1, 1'b0);
    set_in(1, v);
    step(1, "f3_redirect", 1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'd1, 32'd1);
    step(1, "f3_flush1",   1'b0, 32'h0000_0104, 1'b1, 1'b1, 32'd1, 32'd1);
    v.stall = 1'b1;
    set_in(1, v);
    step(1, "f3_stall1",   1'b0, 32'h0000_0104, 1'b1, 1'b1, 32'd1, 32'd1);
    step(1, "f3_stall2",   1'b0, 32'h0000_0104, 1'b1, 1'b1, 32'd1, 32'd1);
    v.stall = 1'b0;
    set_in(1, v);
    step(1, "f3_flush2",   1'b0, 32'h0000_0104, 1'b1, 1'b1, 32'd1, 32'd1);
    step(1, "f3_done",     1'b0, 32'h0000_0104, 1'b0, 1'b0, 32'd1, 32'd1);

    // Reset on the REDIRECT cycle.
    set_in(1, br(BR_BEQ, 32'h0000_0200, 32'h0, 1'b1, 1'b0));
    step(1, "rst_pre", 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'd2, 32'd2);
    v = br(BR_BEQ, 32'h0000_0200, 32'h0, 1'b1, 1'b0);
    v.reset = 1'b1;
    set_in(1, v);
    step(1, "rst_mid", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1, idle);
    step(1, "rst_after", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1, br(BR_BNE, 32'h0000_0040, 32'h0, 1'b0, 1'b0));
    step(1, "post_rst_bne", 1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'd1, 32'd1);
    set_in(1, idle);
    step(1, "post_rst_f1",  1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'd1, 32'd1);
    step(1, "post_rst_f2",  1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'd1, 32'd1);
    step(1, "post_rst_idle", 1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'd1, 32'd1);

    // CNT_W=4: 17 taken branches saturate both counters at 4'hF.
    for (int i = 0; i < 17; i++) begin
      logic [31:0] pc;
      logic [31:0] n;
      pc = 32'h100 + 32'(i) * 32'h10;
      n  = (i + 1 > 15) ? 32'd15 : 32'(i + 1);
      set_in(2, br(BR_BEQ, pc, 32'h0, 1'b1, 1'b0));
      step(2, "sat_redirect", 1'b1, pc, 1'b1, 1'b1, n, n);
      set_in(2, idle);
      step(2, "sat_flush", 1'b0, pc, 1'b1, 1'b1, n, n);
      step(2, "sat_done",  1'b0, pc, 1'b0, 1'b0, n, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
